// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling from a single
// cycle counter, one-cycle done/frame-error pulses and a busy flag.
module uart_rx #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       donerx,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPB  = clk_freq / baud_rate;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  // Counter restarts one cycle after the edge-detect cycle, hence HALF-1.
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          donerx_q, donerx_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          rx_meta_q, rx_s_q, rx_prev_q;

  // Line synchronizer plus previous-sample register for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      donerx_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      donerx_q    <= donerx_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, sampling and pulse generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    donerx_d    = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = {CW{1'b0}};
          bit_d = 3'd0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CW{1'b0}};
          if (rx_s_q) begin
            rx_data_d = shift_q;
            donerx_d  = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      WAIT_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        cnt_d   = {CW{1'b0}};
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign rx_data   = rx_data_q;
  assign donerx    = donerx_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
